// File: rtl/proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | proc_pkg : opcodes, FSM state and ALU operation types for the proc cores     |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JN   = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_RSVD = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEM    = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_t;

  // LD passes the memory operand straight through; ST never reaches the ALU.
  function automatic alu_op_t alu_op_of(input logic [3:0] opcode);
    alu_op_t op;
    case (opcode)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      OP_XOR:  op = ALU_XOR;
      default: op = ALU_PASS;
    endcase
    return op;
  endfunction

  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode >= OP_LD) && (opcode <= OP_XOR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | proc_alu : combinational accumulator ALU, two's complement, modulo 2^DATA_W  |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = b_i;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      default:  y_o = b_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/proc_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | proc_mc  : multi-cycle accumulator core, sync instruction ROM, req/ack dmem  |
// |            Optional CALL/RET return stack enabled by macro PROC_STACK_EN     |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module proc_mc
  import proc_pkg::*;
#(
  parameter int  DATA_W      = 32,
  parameter int  ADDR_W      = 8,
  parameter int  STACK_DEPTH = 4,
  localparam int INSTR_W     = 4 + ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               halted,
  output logic               stack_err
);

  if (DATA_W < 8 || DATA_W < ADDR_W || STACK_DEPTH < 2 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_param_check
    $error("proc_mc: need DATA_W >= max(8, ADDR_W) and STACK_DEPTH a power of two >= 2");
  end

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   acc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic                dmem_req_q;
  logic                dmem_we_q;
  logic                halted_q;

  logic [3:0]          dec_op;
  logic [ADDR_W-1:0]   dec_k;
  logic [3:0]          mem_op;
  logic [ADDR_W-1:0]   pc_inc;
  logic [DATA_W-1:0]   ldi_val;
  logic [DATA_W-1:0]   alu_res;

  // Decode works on the ROM output directly; ir_q only serves the S_MEM phase.
  assign dec_op  = imem_data[INSTR_W-1:ADDR_W];
  assign dec_k   = imem_data[ADDR_W-1:0];
  assign mem_op  = ir_q[INSTR_W-1:ADDR_W];
  assign pc_inc  = pc_q + 1'b1;
  assign ldi_val = DATA_W'($signed(dec_k));

  proc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i (alu_op_of(mem_op)),
    .a_i  (acc_q),
    .b_i  (dmem_rdata),
    .y_o  (alu_res)
  );

`ifdef PROC_STACK_EN
  localparam int             IDX_W   = $clog2(STACK_DEPTH);
  localparam logic [IDX_W:0] SP_FULL = (IDX_W + 1)'(STACK_DEPTH);

  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [IDX_W:0]    sp_q;
  logic [IDX_W:0]    sp_dec;
  logic              stack_err_q;
  logic              push_en;

  assign sp_dec  = sp_q - 1'b1;
  assign push_en = (state_q == S_DECODE) && (dec_op == OP_CALL) && (sp_q != SP_FULL);

  always_ff @(posedge clk) begin
    if (push_en) begin
      stk_q[sp_q[IDX_W-1:0]] <= pc_inc;
    end
  end

  assign stack_err = stack_err_q;
`else
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      acc_q       <= '0;
      ir_q        <= '0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      halted_q    <= 1'b0;
`ifdef PROC_STACK_EN
      sp_q        <= '0;
      stack_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
          state_q <= S_DECODE;
        end

        S_DECODE: begin
          ir_q    <= imem_data;
          state_q <= S_FETCH;
          pc_q    <= pc_inc;
          if (is_mem_op(dec_op)) begin
            state_q    <= S_MEM;
            pc_q       <= pc_q;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (dec_op == OP_ST);
          end else begin
            case (dec_op)
              OP_JMP:  pc_q <= dec_k;
              OP_JZ:   if (acc_q == '0) pc_q <= dec_k;
              OP_JN:   if (acc_q[DATA_W-1]) pc_q <= dec_k;
              OP_LDI:  acc_q <= ldi_val;
`ifdef PROC_STACK_EN
              OP_CALL: begin
                if (sp_q == SP_FULL) begin
                  stack_err_q <= 1'b1;
                  halted_q    <= 1'b1;
                  state_q     <= S_HALT;
                  pc_q        <= pc_q;
                end else begin
                  sp_q <= sp_q + 1'b1;
                  pc_q <= dec_k;
                end
              end
              OP_RET: begin
                if (sp_q == '0) begin
                  stack_err_q <= 1'b1;
                  halted_q    <= 1'b1;
                  state_q     <= S_HALT;
                  pc_q        <= pc_q;
                end else begin
                  sp_q <= sp_dec;
                  pc_q <= stk_q[sp_dec[IDX_W-1:0]];
                end
              end
`endif
              OP_HALT: begin
                halted_q <= 1'b1;
                state_q  <= S_HALT;
                pc_q     <= pc_q;
              end
              default: ;
            endcase
          end
        end

        S_MEM: begin
          if (dmem_ack) begin
            if (mem_op != OP_ST) begin
              acc_q <= alu_res;
            end
            pc_q       <= pc_inc;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            state_q    <= S_FETCH;
          end
        end

        S_HALT: ;

        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = ir_q[ADDR_W-1:0];
  assign dmem_wdata = acc_q;
  assign halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_proc_mc : scoreboard bench, ISA-level reference model vs proc_mc          |
// | Revision   : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_proc_mc;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int IW    = 4 + AW;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;
  logic          halted;
  logic          stack_err;

  proc_mc #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] rom [256];
  logic [DW-1:0] dm  [256];
  logic [DW-1:0] md  [256];

  always @(posedge clk) imem_data <= rom[imem_addr];

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xact_t;

  xact_t exp_q[$];
  int    len_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    wait_min = 0;
  int    wait_max = 0;
  bit    hold = 1'b0;
  bit    m_halted;
  bit    m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder and scoreboard monitor: pops one expectation per handshake.
  initial begin : responder
    int    cnt;
    int    len;
    xact_t snap;
    xact_t cur;
    xact_t e;
    cnt = -1;
    len = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (rst || !dmem_req) begin
        cnt = -1;
        len = 0;
      end else begin
        cur = {dmem_we, dmem_addr, dmem_wdata};
        if (len == 0) begin
          snap = cur;
          cnt  = hold ? (1 << 30) : int'($urandom_range(wait_max, wait_min));
        end
        len++;
        if (cnt == 0) begin
          check("req_stable", cur, snap);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL xact_unexpected: got we=%0d addr=%0h wdata=%0h, expected none",
                     cur.we, cur.addr, cur.wdata);
          end else begin
            e = exp_q.pop_front();
            check("xact_we", cur.we, e.we);
            check("xact_addr", cur.addr, e.addr);
            check("xact_wdata", cur.wdata, e.wdata);
          end
          dmem_rdata = dm[dmem_addr];
          if (dmem_we) dm[dmem_addr] = dmem_wdata;
          dmem_ack = 1'b1;
          len_q.push_back(len);
          cnt = -1;
          len = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Instruction-set level interpreter; fills the scoreboard and the expected memory image.
  task automatic model_run(output bit ok);
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic [DW-1:0] v;
    logic [IW-1:0] ins;
    logic [3:0]    op;
    logic [AW-1:0] k;
    logic [AW-1:0] stk[$];
    int            steps;
    int            sk;
    exp_q.delete();
    len_q.delete();
    for (int i = 0; i < 256; i++) md[i] = dm[i];
    pc = '0; acc = '0; m_err = 1'b0; m_halted = 1'b0; steps = 0;
    while (!m_halted && steps < 200) begin
      ins = rom[pc];
      op  = ins[IW-1:AW];
      k   = ins[AW-1:0];
      steps++;
      if (op >= 4'd1 && op <= 4'd7) begin
        exp_q.push_back({op == 4'd2, k, acc});
        v = md[k];
        case (op)
          4'd1: acc = v;
          4'd2: md[k] = acc;
          4'd3: acc = acc + v;
          4'd4: acc = acc - v;
          4'd5: acc = acc & v;
          4'd6: acc = acc | v;
          default: acc = acc ^ v;
        endcase
        pc = pc + 8'd1;
      end else begin
        case (op)
          4'd8:  pc = k;
          4'd9:  pc = (acc == 0) ? k : pc + 8'd1;
          4'd10: pc = ($signed(acc) < 0) ? k : pc + 8'd1;
          4'd11: begin
            sk  = (k >= 8'd128) ? int'(k) - 256 : int'(k);
            acc = sk;
            pc  = pc + 8'd1;
          end
`ifdef PROC_STACK_EN
          4'd12: begin
            if (stk.size() == DEPTH) begin m_err = 1'b1; m_halted = 1'b1; end
            else begin stk.push_back(pc + 8'd1); pc = k; end
          end
          4'd13: begin
            if (stk.size() == 0) begin m_err = 1'b1; m_halted = 1'b1; end
            else pc = stk.pop_back();
          end
`endif
          4'd15: m_halted = 1'b1;
          default: pc = pc + 8'd1;
        endcase
      end
    end
    ok = m_halted;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("halted", halted, 1);
  endtask

  task automatic final_checks();
    int bad;
    repeat (3) @(negedge clk);
    check("halt_quiet", dmem_req, 0);
    check("stack_err", stack_err, m_err);
    check("sb_drained", exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (dm[i] !== md[i]) bad++;
    check("dmem_image_diffs", bad, 0);
  endtask

  task automatic run_prog(input int wmin, input int wmax, output int cyc);
    bit ok;
    wait_min = wmin;
    wait_max = wmax;
    model_run(ok);
    do_reset();
    wait_halt(cyc);
    final_checks();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin
      rom[i] = {4'hF, 8'h00};
      dm[i]  = '0;
    end
  endtask

  task automatic gen_random();
    int        len;
    logic [3:0] op;
    logic [7:0] k;
    int        sel;
    clear_all();
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: dm[i] = 32'h0;
        1: dm[i] = 32'h7FFF_FFFF;
        2: dm[i] = 32'h8000_0000;
        3: dm[i] = 32'hFFFF_FFFF;
        default: dm[i] = $urandom;
      endcase
    end
    len = $urandom_range(8, 30);
    for (int i = 0; i < len; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 1) == 0) op = 4'h3;
      if (op >= 4'h1 && op <= 4'h7)             k = 8'($urandom_range(0, 15));
      else if (op == 4'hB)                      k = 8'($urandom);
      else                                      k = 8'($urandom_range(0, len - 1));
      rom[i] = {op, k};
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    int w;
    bit ok;
    int tries;
    clear_all();
    repeat (3) @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_halted", halted, 0);
    check("rst_stack_err", stack_err, 0);
    check("rst_pc", imem_addr, 0);

    // LDI 5; ADD M[3]; ST 4; HALT with same-cycle ack
    clear_all();
    rom[0] = 12'hB05; rom[1] = 12'h303; rom[2] = 12'h204; rom[3] = 12'hF00;
    dm[3] = 32'd7;
    run_prog(0, 0, cyc);
    check("t1_m4", dm[4], 32'd12);
    check("t1_cycles", cyc, 10);

    // four wait states on LD
    clear_all();
    rom[0] = 12'h103; rom[1] = 12'h204; rom[2] = 12'hF00;
    dm[3] = 32'h0000_A5A5;
    run_prog(4, 4, cyc);
    check("t2_req_cycles", (len_q.size() > 0) ? len_q[0] : -1, 5);
    check("t2_m4", dm[4], 32'h0000_A5A5);

    // branches
    clear_all();
    rom[8'h00] = 12'hBFF; rom[8'h01] = 12'hA20; rom[8'h02] = 12'h206;
    rom[8'h20] = 12'hB00; rom[8'h21] = 12'h930;
    rom[8'h30] = 12'hB01; rom[8'h31] = 12'h950; rom[8'h32] = 12'h207; rom[8'h33] = 12'hF00;
    rom[8'h50] = 12'h208;
    run_prog(0, 2, cyc);
    check("t3_m7", dm[7], 32'd1);

    // pc wrap at 0xFF and signed overflow of ADD
    clear_all();
    rom[8'h00] = 12'hA10; rom[8'h01] = 12'hBFF; rom[8'h02] = 12'h8FF; rom[8'hFF] = 12'h000;
    rom[8'h10] = 12'h201; rom[8'h11] = 12'h102; rom[8'h12] = 12'h303;
    rom[8'h13] = 12'h204; rom[8'h14] = 12'hF00;
    dm[2] = 32'h7FFF_FFFF; dm[3] = 32'd1;
    run_prog(0, 2, cyc);
    check("t4_m1", dm[1], 32'hFFFF_FFFF);
    check("t4_m4", dm[4], 32'h8000_0000);

    // reset while a memory access is stalled
    clear_all();
    rom[0] = 12'h103; rom[1] = 12'h209; rom[2] = 12'hF00;
    dm[3] = 32'h0000_1234; dm[9] = 32'h0000_DEAD;
    wait_min = 0; wait_max = 1;
    model_run(ok);
    hold = 1'b1;
    do_reset();
    w = 0;
    while (!dmem_req && w < 20) begin @(negedge clk); w++; end
    check("t5_req_seen", dmem_req, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("t5_req_drop", dmem_req, 0);
    @(negedge clk);
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_pc", imem_addr, 0);
    check("t5_halted", halted, 0);
    wait_halt(cyc);
    final_checks();
    check("t5_m9", dm[9], 32'h0000_1234);

    // nested CALL/RET
    clear_all();
    rom[8'h00] = 12'hC10; rom[8'h01] = 12'h201; rom[8'h02] = 12'hF00;
    rom[8'h10] = 12'hC20; rom[8'h11] = 12'h202; rom[8'h12] = 12'hD00;
    rom[8'h20] = 12'hB03; rom[8'h21] = 12'hD00;
    dm[1] = 32'h55; dm[2] = 32'h66;
    run_prog(0, 1, cyc);
`ifdef PROC_STACK_EN
    check("t6_nest_m2", dm[2], 32'd3);
    check("t6_nest_m1", dm[1], 32'd3);
`else
    check("t6_nop_m1", dm[1], 32'd0);
`endif

    // stack overflow on the fifth nested CALL
    clear_all();
    rom[8'h00] = 12'h840;
    for (int i = 0; i < 5; i++) rom[8'h40 + i] = {4'hC, 8'(8'h41 + i)};
    rom[8'h45] = 12'h201;
    run_prog(0, 0, cyc);
`ifdef PROC_STACK_EN
    check("t6_ovf_err", stack_err, 1);
    check("t6_ovf_halted", halted, 1);
`endif

    // RET on empty stack
    clear_all();
    rom[0] = 12'hD00; rom[1] = 12'h201; rom[2] = 12'hF00;
    run_prog(0, 0, cyc);
`ifdef PROC_STACK_EN
    check("t6_unf_err", stack_err, 1);
`endif

    // random programs
    for (int t = 0; t < 25; t++) begin
      ok = 1'b0;
      tries = 0;
      while (!ok && tries < 20) begin
        gen_random();
        model_run(ok);
        tries++;
      end
      if (ok) begin
        wait_min = 0;
        wait_max = 3;
        do_reset();
        wait_halt(cyc);
        final_checks();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
